// File: rtl/receptor_16b_pkg.sv
// rtl/receptor_16b_pkg.sv - shared constants, state types and sizing helper for receptor_16b
package receptor_16b_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_TIMEOUT_BITS = 20;
  localparam int FRAME_BITS       = 8;

  // byte engine states; the inter-byte GAP phase lives in the word assembler
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

  // word assembler phases
  typedef enum logic [1:0] {
    W_IDLE,
    W_BYTE1,
    W_GAP,
    W_BYTE2
  } word_state_t;

  // one counter width covers both the bit timer and the longest inter-byte gap
  function automatic int cnt_width(input int clks_per_bit, input int timeout_bits);
    return $clog2(clks_per_bit * timeout_bits + 1);
  endfunction

endpackage

// File: rtl/receptor_16b_rx_byte_sampler.sv
// rtl/receptor_16b_rx_byte_sampler.sv - rx synchronizer plus start/data/stop byte engine
module rx_byte_sampler
  import receptor_16b_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CW           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       byte_err,
  output logic       line_low,
  output logic       active
);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(FRAME_BITS - 1);

  logic [1:0]    sync_q, sync_d;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_s;

  assign sync_d   = {sync_q[0], rx};
  assign rx_s     = sync_q[1];
  assign line_low = (state_q == ST_IDLE) && !rx_s;
  assign active   = (state_q != ST_IDLE);
  assign rx_byte  = shift_q;

  // register stage: synchronizer resets to idle-line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // bit timing: recheck start at half bit, then sample every full bit from there
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    byte_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          state_d   = ST_IDLE;
          byte_done = rx_s;
          byte_err  = !rx_s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/receptor_16b.sv
// rtl/receptor_16b.sv - two-byte UART receiver assembling 16-bit words
module receptor_16b
  import receptor_16b_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
  input  logic        clk_50mhz,
  input  logic        reset_n,
  input  logic        rx,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int            CW       = cnt_width(CLKS_PER_BIT, TIMEOUT_BITS);
  localparam logic [CW-1:0] GAP_LAST = CW'(CLKS_PER_BIT * TIMEOUT_BITS - 1);

  logic [7:0]    rx_byte;
  logic          byte_done, byte_err, line_low, active;

  word_state_t   state_q, state_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [7:0]    upper_q, upper_d;
  logic [15:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  rx_byte_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CW          (CW)
  ) u_sampler (
    .clk      (clk_50mhz),
    .rst_n    (reset_n),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .byte_done(byte_done),
    .byte_err (byte_err),
    .line_low (line_low),
    .active   (active)
  );

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != W_IDLE);

  // register stage: reset drops any partial word without pulsing
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= W_IDLE;
      gap_q   <= '0;
      upper_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      upper_q <= upper_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // word assembly: byte index, inter-byte timeout, single-cycle result pulses
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    upper_d = upper_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (line_low) state_d = W_BYTE1;
      end
      W_BYTE1: begin
        if (byte_err) begin
          err_d   = 1'b1;
          state_d = W_IDLE;
        end else if (byte_done) begin
          upper_d = rx_byte;
          gap_d   = '0;
          state_d = W_GAP;
        end else if (!active && !line_low) begin
          state_d = W_IDLE;
        end
      end
      W_GAP: begin
        if (line_low) begin
          state_d = W_BYTE2;
        end else if (gap_q == GAP_LAST) begin
          err_d   = 1'b1;
          state_d = W_IDLE;
        end else begin
          gap_d = gap_q + CW'(1);
        end
      end
      W_BYTE2: begin
        if (byte_err) begin
          err_d   = 1'b1;
          state_d = W_IDLE;
        end else if (byte_done) begin
          data_d  = {upper_q, rx_byte};
          valid_d = 1'b1;
          state_d = W_IDLE;
        end else if (!active && !line_low) begin
          state_d = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_receptor_16b.sv
// tb/tb_receptor_16b.sv - directed checks for receptor_16b with 16 clocks per bit
module tb_receptor_16b;

  localparam int CPB    = 16;
  localparam int TOB    = 20;
  localparam int BIT_NS = CPB * 10;

  logic        clk_50mhz = 1'b0;
  logic        reset_n;
  logic        rx;
  logic [15:0] data;
  logic        data_valid;
  logic        frame_err;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  int          nwords = 0;
  logic [15:0] words [64];

  typedef struct {
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          idle_bits;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  receptor_16b #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .reset_n   (reset_n),
    .rx        (rx),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  always @(negedge clk_50mhz) begin
    if (data_valid) begin
      valid_cnt++;
      if (nwords < 64) begin
        words[nwords] = data;
        nwords++;
      end
    end
    if (frame_err) err_cnt++;
    if (data_valid && frame_err) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
    rx = 1'b1;
  endtask

  initial begin
    int v0, e0, w0;
    logic [15:0] exp_data;

    vecs[0] = '{8'hA5, 8'h3C, 1,  16'hA53C};
    vecs[1] = '{8'h00, 8'hFF, 0,  16'h00FF};
    vecs[2] = '{8'hFF, 8'h00, 3,  16'hFF00};
    vecs[3] = '{8'h80, 8'h01, 2,  16'h8001};
    vecs[4] = '{8'hC3, 8'h5A, 18, 16'hC35A};
    vecs[5] = '{8'h12, 8'h34, 0,  16'h1234};

    rx      = 1'b1;
    reset_n = 1'b0;
    #32;
    check("reset_data", 32'(data), 32'h0);
    check("reset_valid", 32'(data_valid), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    #(2 * BIT_NS);

    // table: byte pairs with varying idle gap, including near-timeout
    for (int k = 0; k < 6; k++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(vecs[k].b1, 1'b1, BIT_NS);
      #(vecs[k].idle_bits * BIT_NS);
      send_frame(vecs[k].b2, 1'b1, BIT_NS);
      #(2 * BIT_NS);
      check("vec_valid_count", 32'(valid_cnt - v0), 32'd1);
      check("vec_err_count", 32'(err_cnt - e0), 32'd0);
      check("vec_data", 32'(data), 32'(vecs[k].exp));
      check("vec_busy_after", 32'(busy), 32'h0);
    end
    exp_data = 16'h1234;

    // byte 1 with bad stop bit
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'h5C, 1'b0, BIT_NS);
    #(40 * BIT_NS);
    check("stop0_err", 32'(err_cnt - e0), 32'd1);
    check("stop0_valid", 32'(valid_cnt - v0), 32'd0);
    check("stop0_data_held", 32'(data), 32'(exp_data));
    check("stop0_busy", 32'(busy), 32'h0);

    // start glitch shorter than half a bit
    v0 = valid_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    #50;
    rx = 1'b1;
    #300;
    check("glitch_busy", 32'(busy), 32'h0);
    check("glitch_err", 32'(err_cnt - e0), 32'd0);
    check("glitch_valid", 32'(valid_cnt - v0), 32'd0);

    // inter-byte timeout then a clean pair
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'h55, 1'b1, BIT_NS);
    #(21 * BIT_NS);
    check("timeout_err", 32'(err_cnt - e0), 32'd1);
    check("timeout_busy", 32'(busy), 32'h0);
    send_frame(8'h12, 1'b1, BIT_NS);
    #(BIT_NS);
    send_frame(8'h34, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    check("after_timeout_valid", 32'(valid_cnt - v0), 32'd1);
    check("after_timeout_data", 32'(data), 32'h1234);
    check("after_timeout_err", 32'(err_cnt - e0), 32'd1);

    // reset asserted partway through byte 2
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'h77, 1'b1, BIT_NS);
    #(BIT_NS);
    rx = 1'b0;
    #(BIT_NS);
    rx = 1'b1;
    #(BIT_NS);
    rx = 1'b0;
    #(BIT_NS / 2);
    reset_n = 1'b0;
    #3;
    check("midreset_data", 32'(data), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_valid", 32'(data_valid), 32'h0);
    check("midreset_err", 32'(frame_err), 32'h0);
    #30;
    rx = 1'b1;
    reset_n = 1'b1;
    #(2 * BIT_NS);
    check("midreset_no_pulse", 32'((valid_cnt - v0) + (err_cnt - e0)), 32'd0);
    send_frame(8'hBE, 1'b1, BIT_NS);
    #(BIT_NS);
    send_frame(8'hEF, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    check("post_reset_data", 32'(data), 32'hBEEF);
    check("post_reset_valid", 32'(valid_cnt - v0), 32'd1);

    // three back-to-back words, slow then fast bit period
    for (int p = 0; p < 2; p++) begin
      int bns;
      bns = (p == 0) ? 165 : 155;
      w0 = nwords;
      e0 = err_cnt;
      send_frame(8'hDE, 1'b1, bns);
      send_frame(8'hAD, 1'b1, bns);
      send_frame(8'h01, 1'b1, bns);
      send_frame(8'h23, 1'b1, bns);
      send_frame(8'hF0, 1'b1, bns);
      send_frame(8'h0F, 1'b1, bns);
      #(2 * BIT_NS);
      check("b2b_count", 32'(nwords - w0), 32'd3);
      check("b2b_err", 32'(err_cnt - e0), 32'd0);
      if (nwords - w0 == 3) begin
        check("b2b_word0", 32'(words[w0]), 32'hDEAD);
        check("b2b_word1", 32'(words[w0 + 1]), 32'h0123);
        check("b2b_word2", 32'(words[w0 + 2]), 32'hF00F);
      end
    end

    check("never_both_pulses", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
